pattern_controller: RTL and testbench
=====================================

PATTERN_CONTROLLER -- requirements
Module: pattern_controller

Interface
REQ-001 Parameter NUM_BUTTONS, default 4: number of pulse requesters; legal range 2..8.
REQ-002 Parameter PATTERN_LEN, default 4: entries per pattern; legal range 1..8.
REQ-003 Parameter TIMEOUT_CYCLES, default 100_000_000: idle cycles allowed between entries.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset is asynchronous and active-low.
REQ-006 btn_pulse  input  NUM_BUTTONS  one-cycle pulses, one bit per button, from upstream edge-to-pulse stages.
REQ-007 pattern_load  input  1  one-cycle strobe; captures pattern_in.
REQ-008 pattern_in  input  PATTERN_LEN*IDX_W  packed button indices; entry 0 in the LSBs.
REQ-009 busy  output  1  high while in COLLECT.
REQ-010 progress  output  CNT_W  number of entries accepted in the current attempt.
REQ-011 match  output  1  one-cycle pulse on a correct full sequence.
REQ-012 fail  output  1  one-cycle pulse on a wrong sequence or timeout.
REQ-013 locked  output  1  lockout active (see Configuration).

Function
REQ-014 Widths: IDX_W = max(1,$clog2(NUM_BUTTONS)); CNT_W = $clog2(PATTERN_LEN+1).
REQ-015 States: IDLE, COLLECT, MATCH, FAIL, plus LOCKED when configured.
REQ-016 An entry is any cycle with btn_pulse != 0.
  - Exactly one bit set: entry index = that bit.
  - More than one bit set: invalid entry; counted and marked as a mismatch.
REQ-017 IDLE: an entry compares against pattern entry 0, sets progress=1, and moves to COLLECT in the same cycle.
  - If PATTERN_LEN==1, the entry instead resolves directly to MATCH or FAIL.
REQ-018 COLLECT: each entry is compared against pattern entry [progress].
  - Any mismatch sets a sticky mismatch flag; progress increments.
  - No early abort on mismatch.
REQ-019 When the PATTERN_LEN-th entry is accepted: next state is MATCH if the mismatch flag (including that entry) is clear, otherwise FAIL.
REQ-020 MATCH and FAIL each last one cycle, asserting match or fail respectively.
  - On exit: progress=0, mismatch flag cleared, next state IDLE (or LOCKED per REQ-029).
  - Entries arriving during MATCH/FAIL are discarded.
REQ-021 Timeout counter: cleared on every accepted entry; increments each COLLECT cycle without an entry.
  - On reaching TIMEOUT_CYCLES-1: next state FAIL.
  - An entry in that same cycle takes priority over the timeout.
REQ-022 pattern_load is honoured only in IDLE with no entry in the same cycle; otherwise ignored.
  - The new pattern applies from the next cycle.
REQ-023 Output timing: match, fail, busy and locked are registered (Moore) outputs; match/fail rise exactly one cycle after the completing entry.

Reset
REQ-024 While reset_n is low: state=IDLE, progress=0, mismatch flag=0, timeout counter=0, fail counter=0, match=0, fail=0, busy=0, locked=0.
  - Stored pattern resets to all-zero indices.
REQ-025 Reset asserted mid-COLLECT abandons the attempt; no fail pulse is produced.

Configuration
REQ-026 Macro PATTERN_CTRL_LOCKOUT_EN compiles in lockout.
REQ-027 With the macro: a 2-bit consecutive-fail counter increments on each FAIL and clears on MATCH.
  - The third consecutive FAIL enters LOCKED instead of IDLE.
REQ-028 LOCKED lasts LOCKOUT_CYCLES (parameter, default 500_000_000).
  - locked=1; entries and pattern_load ignored.
  - Exit to IDLE with the fail counter cleared.
REQ-029 Without the macro: no LOCKED state, no fail counter, locked tied to 0, LOCKOUT_CYCLES unused.

Structure
REQ-030 Package pattern_ctrl_pkg holds the state enum type and width helper functions (IDX_W, CNT_W).
REQ-031 Sub-module timeout_counter (parameter MAX; inputs clk, reset_n, clear, enable; output expired) is used for both the inter-entry timeout and the lockout timer.
REQ-032 The controller has one FSM: a combinational next-state block plus an async-reset registered state.

Verification
REQ-033 Pattern {2,0,3,1} loaded; pulses on buttons 2,0,3,1 spaced 5 cycles -> progress 1..4, match=1 for one cycle 1 cycle after last pulse, fail stays 0.
REQ-034 Same pattern; pulses 2,1,3,1 -> no early abort, progress reaches 4, fail pulse after 4th entry, match stays 0.
REQ-035 TIMEOUT_CYCLES=10; one pulse on button 2 then silence -> fail pulse 10 cycles after entry, progress returns to 0.
REQ-036 btn_pulse=4'b0101 as first entry, then 0,3,1 -> fail after 4th entry; pattern_load pulsed during COLLECT -> stored pattern unchanged.
REQ-037 reset_n dropped mid-COLLECT (progress=2) -> all outputs 0 immediately, no fail pulse, next correct sequence matches.
REQ-038 With PATTERN_CTRL_LOCKOUT_EN, LOCKOUT_CYCLES=20: three wrong sequences -> locked=1 for 20 cycles, entries ignored; correct sequence afterwards -> match.

Source files
------------

// File: rtl/pattern_ctrl_pkg.sv
// Purpose: shared FSM state type and port-width helpers for pattern_controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Macro PATTERN_CTRL_LOCKOUT_EN adds the LOCKED state to the enum.
package pattern_ctrl_pkg;

`ifdef PATTERN_CTRL_LOCKOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_MATCH,
    ST_FAIL,
    ST_LOCKED
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_MATCH,
    ST_FAIL
  } state_e;
`endif

  // Bits needed to hold one button index; never less than one bit.
  function automatic int idx_w(input int num_buttons);
    return (num_buttons > 2) ? $clog2(num_buttons) : 1;
  endfunction

  // Bits needed to count 0..pattern_len accepted entries.
  function automatic int cnt_w(input int pattern_len);
    return $clog2(pattern_len + 1);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Purpose: cycle counter that flags the MAX-th consecutive enabled cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clear has priority over enable.
// Ports: clk, reset_n (async, active-low), clear, enable, expired.
module timeout_counter #(
  parameter int MAX = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W    = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0]  LAST = W'(MAX - 1);

  logic [W-1:0] count_q;

  // The count reads k-1 during the k-th enabled cycle, so expired marks the
  // MAX-th one. Holding at LAST keeps the counter from wrapping if the owner
  // leaves enable high.
  assign expired = enable && (count_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/pattern_controller.sv
// Purpose: compares a stream of button pulses against a loaded index pattern.
// Latency: match/fail/busy/locked are registered, one cycle after the deciding input.
// Backpressure: none; entries arriving in MATCH/FAIL/LOCKED are dropped.
// Ports: clk, reset_n, btn_pulse, pattern_load, pattern_in -> busy, progress, match, fail, locked.
// Macro PATTERN_CTRL_LOCKOUT_EN enables the consecutive-fail lockout (LOCKED state).
module pattern_controller
  import pattern_ctrl_pkg::*;
#(
  parameter int  NUM_BUTTONS    = 4,
  parameter int  PATTERN_LEN    = 4,
  parameter int  TIMEOUT_CYCLES = 100_000_000,
  parameter int  LOCKOUT_CYCLES = 500_000_000,
  localparam int IDX_W          = idx_w(NUM_BUTTONS),
  localparam int CNT_W          = cnt_w(PATTERN_LEN)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_BUTTONS-1:0]       btn_pulse,
  input  logic                         pattern_load,
  input  logic [PATTERN_LEN*IDX_W-1:0] pattern_in,
  output logic                         busy,
  output logic [CNT_W-1:0]             progress,
  output logic                         match,
  output logic                         fail,
  output logic                         locked
);

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_BUTTONS < 2 || NUM_BUTTONS > 8 || PATTERN_LEN < 1 || PATTERN_LEN > 8 ||
      TIMEOUT_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("pattern_controller: parameter out of range");
  end

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             progress_q, progress_d;
  logic                         mismatch_q, mismatch_d;
  logic [PATTERN_LEN*IDX_W-1:0] pattern_q, pattern_d;
  logic                         match_q, fail_q, busy_q;

  logic             entry_vld, entry_ok, last_entry, tmo_expired;
  logic             tmo_clear, tmo_enable;
  logic [IDX_W-1:0] entry_idx, expected_idx;

  assign entry_vld = |btn_pulse;

  always_comb begin
    entry_idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (btn_pulse[i]) entry_idx = IDX_W'(i);
    end
    expected_idx = '0;
    for (int i = 0; i < PATTERN_LEN; i++) begin
      if (progress_q == CNT_W'(i)) expected_idx = pattern_q[i*IDX_W +: IDX_W];
    end
  end

  // A multi-bit pulse is an invalid entry: it still advances progress but
  // can never match.
  assign entry_ok   = $onehot(btn_pulse) && (entry_idx == expected_idx);
  // progress is 0 in IDLE, so this also covers the single-entry pattern.
  assign last_entry = (progress_q == CNT_W'(PATTERN_LEN - 1));

  assign tmo_clear  = (state_q != ST_COLLECT) || entry_vld;
  assign tmo_enable = (state_q == ST_COLLECT) && !entry_vld;

  timeout_counter #(.MAX(TIMEOUT_CYCLES)) u_entry_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

`ifdef PATTERN_CTRL_LOCKOUT_EN
  logic [1:0] fail_cnt_q, fail_cnt_d;
  logic       lock_expired, lock_clear, lock_enable;
  logic       locked_q;

  assign lock_clear  = (state_q != ST_LOCKED);
  assign lock_enable = (state_q == ST_LOCKED);

  timeout_counter #(.MAX(LOCKOUT_CYCLES)) u_lock_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (lock_clear),
    .enable  (lock_enable),
    .expired (lock_expired)
  );
`endif

  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    mismatch_d = mismatch_q;
    pattern_d  = pattern_q;
`ifdef PATTERN_CTRL_LOCKOUT_EN
    fail_cnt_d = fail_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (entry_vld) begin
          progress_d = CNT_W'(1);
          mismatch_d = !entry_ok;
          if (last_entry) state_d = entry_ok ? ST_MATCH : ST_FAIL;
          else            state_d = ST_COLLECT;
        end else if (pattern_load) begin
          pattern_d = pattern_in;
        end
      end
      ST_COLLECT: begin
        // An entry in the expiry cycle wins over the timeout.
        if (entry_vld) begin
          progress_d = progress_q + CNT_W'(1);
          mismatch_d = mismatch_q || !entry_ok;
          if (last_entry) state_d = (mismatch_q || !entry_ok) ? ST_FAIL : ST_MATCH;
        end else if (tmo_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_MATCH: begin
        progress_d = '0;
        mismatch_d = 1'b0;
        state_d    = ST_IDLE;
`ifdef PATTERN_CTRL_LOCKOUT_EN
        fail_cnt_d = 2'd0;
`endif
      end
      ST_FAIL: begin
        progress_d = '0;
        mismatch_d = 1'b0;
        state_d    = ST_IDLE;
`ifdef PATTERN_CTRL_LOCKOUT_EN
        fail_cnt_d = fail_cnt_q + 2'd1;
        if (fail_cnt_q == 2'd2) state_d = ST_LOCKED;
`endif
      end
`ifdef PATTERN_CTRL_LOCKOUT_EN
      ST_LOCKED: begin
        if (lock_expired) begin
          state_d    = ST_IDLE;
          fail_cnt_d = 2'd0;
        end
      end
`endif
      default: begin
        state_d    = ST_IDLE;
        progress_d = '0;
        mismatch_d = 1'b0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the
  // registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      progress_q <= '0;
      mismatch_q <= 1'b0;
      pattern_q  <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      mismatch_q <= mismatch_d;
      pattern_q  <= pattern_d;
      match_q    <= (state_d == ST_MATCH);
      fail_q     <= (state_d == ST_FAIL);
      busy_q     <= (state_d == ST_COLLECT);
    end
  end

`ifdef PATTERN_CTRL_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      locked_q   <= (state_d == ST_LOCKED);
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign busy     = busy_q;
  assign progress = progress_q;
  assign match    = match_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_pattern_controller.sv
// Purpose: self-checking bench for pattern_controller against a queue-based model.
// Latency: model predicts outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; every loop is a fixed cycle count.
module tb_pattern_controller;

  localparam int NB  = 4;
  localparam int PL  = 4;
  localparam int TMO = 10;
  localparam int LCK = 20;

  localparam int PH_IDLE    = 0;
  localparam int PH_COLLECT = 1;
  localparam int PH_MATCH   = 2;
  localparam int PH_FAIL    = 3;
  localparam int PH_LOCKED  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn_pulse;
  logic       pattern_load;
  logic [7:0] pattern_in;
  logic       busy, match, fail, locked;
  logic [2:0] progress;
  logic [6:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: stored pattern, entries of the current attempt, phase.
  int mp[PL];
  int got[$];
  int m_phase, idle_run, lock_left, consec;

  always #5 clk = ~clk;

  pattern_controller #(
    .NUM_BUTTONS   (NB),
    .PATTERN_LEN   (PL),
    .TIMEOUT_CYCLES(TMO),
    .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_pulse   (btn_pulse),
    .pattern_load(pattern_load),
    .pattern_in  (pattern_in),
    .busy        (busy),
    .progress    (progress),
    .match       (match),
    .fail        (fail),
    .locked      (locked)
  );

  assign dut_vec = {busy, locked, match, fail, progress};

  function automatic int decode(input logic [3:0] b);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < NB; i++) begin
      if (b[i]) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_phase == PH_COLLECT, m_phase == PH_LOCKED, m_phase == PH_MATCH,
            m_phase == PH_FAIL, 3'(got.size())};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PL; i++) mp[i] = 0;
    got.delete();
    m_phase   = PH_IDLE;
    idle_run  = 0;
    lock_left = 0;
    consec    = 0;
  endtask

  task automatic model_resolve();
    bit ok = 1'b1;
    for (int i = 0; i < PL; i++) if (got[i] != mp[i]) ok = 1'b0;
    m_phase = ok ? PH_MATCH : PH_FAIL;
  endtask

  task automatic model_step(input logic [3:0] b, input logic ld, input logic [7:0] p);
    case (m_phase)
      PH_IDLE: begin
        if (b != 4'b0) begin
          got.push_back(decode(b));
          if (got.size() == PL) model_resolve();
          else begin
            m_phase  = PH_COLLECT;
            idle_run = 0;
          end
        end else if (ld) begin
          for (int i = 0; i < PL; i++) mp[i] = int'(p[2*i +: 2]);
        end
      end
      PH_COLLECT: begin
        if (b != 4'b0) begin
          got.push_back(decode(b));
          idle_run = 0;
          if (got.size() == PL) model_resolve();
        end else begin
          idle_run++;
          if (idle_run == TMO) m_phase = PH_FAIL;
        end
      end
      PH_MATCH: begin
        got.delete();
        consec  = 0;
        m_phase = PH_IDLE;
      end
      PH_FAIL: begin
        got.delete();
        consec++;
        m_phase = PH_IDLE;
`ifdef PATTERN_CTRL_LOCKOUT_EN
        if (consec == 3) begin
          m_phase   = PH_LOCKED;
          lock_left = LCK;
        end
`endif
      end
      default: begin
        lock_left--;
        if (lock_left == 0) begin
          m_phase = PH_IDLE;
          consec  = 0;
        end
      end
    endcase
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic cyc(input logic [3:0] b, input logic ld, input logic [7:0] p);
    btn_pulse    = b;
    pattern_load = ld;
    pattern_in   = p;
    @(posedge clk);
    model_step(b, ld, p);
    #1;
    btn_pulse    = 4'b0;
    pattern_load = 1'b0;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    btn_pulse    = 4'b0100;
    pattern_load = 1'b1;
    pattern_in   = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", dut_vec, exp_vec());
    end
    btn_pulse    = 4'b0;
    pattern_load = 1'b0;
    reset_n      = 1'b1;
    // Stored pattern must be all-zero after reset: 0,0,0,0 matches.
    for (int k = 0; k < 6; k++) begin
      cyc((k < 4) ? 4'b0001 : 4'b0, 1'b0, 8'h00);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_zero_pattern cyc %0d: got %b expected %b", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_match();
    logic [3:0] seq[4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    int n_match = 0, n_fail = 0, max_prog = 0;
    hard_reset();
    cyc(4'b0, 1'b1, 8'h72);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 5; g++) begin
        cyc((g == 0) ? seq[k] : 4'b0, 1'b0, 8'h00);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL match_seq e%0d g%0d: got %b expected %b", k, g, dut_vec, exp_vec());
        end
        n_match += int'(match);
        n_fail  += int'(fail);
        if (int'(progress) > max_prog) max_prog = int'(progress);
      end
    end
    checks++;
    if (n_match != 1 || n_fail != 0 || max_prog != 4) begin
      errors++;
      $display("FAIL match_summary: match=%0d fail=%0d maxprog=%0d required 1 0 4",
               n_match, n_fail, max_prog);
    end
  endtask

  task automatic test_mismatch();
    logic [3:0] seq[4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0010};
    int n_match = 0, n_fail = 0, max_prog = 0;
    hard_reset();
    cyc(4'b0, 1'b1, 8'h72);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 5; g++) begin
        cyc((g == 0) ? seq[k] : 4'b0, 1'b0, 8'h00);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL mismatch_seq e%0d g%0d: got %b expected %b", k, g, dut_vec, exp_vec());
        end
        n_match += int'(match);
        n_fail  += int'(fail);
        if (int'(progress) > max_prog) max_prog = int'(progress);
      end
    end
    checks++;
    if (n_match != 0 || n_fail != 1 || max_prog != 4) begin
      errors++;
      $display("FAIL mismatch_summary: match=%0d fail=%0d maxprog=%0d required 0 1 4",
               n_match, n_fail, max_prog);
    end
  endtask

  task automatic test_timeout();
    int fail_at = -1;
    hard_reset();
    cyc(4'b0, 1'b1, 8'h72);
    cyc(4'b0100, 1'b0, 8'h00);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_entry: got %b expected %b", dut_vec, exp_vec());
    end
    for (int k = 1; k <= 14; k++) begin
      cyc(4'b0, 1'b0, 8'h00);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_wait k%0d: got %b expected %b", k, dut_vec, exp_vec());
      end
      if (fail && fail_at < 0) fail_at = k;
    end
    checks++;
    if (fail_at != TMO || progress !== 3'd0) begin
      errors++;
      $display("FAIL timeout_summary: fail after %0d cycles progress=%0d required %0d and 0",
               fail_at, progress, TMO);
    end
  endtask

  task automatic test_invalid_and_load();
    logic [3:0] bad[4]  = '{4'b0101, 4'b0001, 4'b1000, 4'b0010};
    logic [3:0] good[4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    int n_match = 0, n_fail = 0;
    hard_reset();
    cyc(4'b0, 1'b1, 8'h72);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 3; g++) begin
        // A load strobe mid-attempt must not replace the stored pattern.
        cyc((g == 0) ? bad[k] : 4'b0, (g == 1), 8'h1B);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL invalid_seq e%0d g%0d: got %b expected %b", k, g, dut_vec, exp_vec());
        end
        n_fail += int'(fail);
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 3; g++) begin
        // Load coinciding with the first entry in IDLE is also ignored.
        cyc((g == 0) ? good[k] : 4'b0, (k == 0 && g == 0), 8'hE4);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL load_ignored e%0d g%0d: got %b expected %b", k, g, dut_vec, exp_vec());
        end
        n_match += int'(match);
      end
    end
    checks++;
    if (n_fail != 1 || n_match != 1) begin
      errors++;
      $display("FAIL invalid_summary: fail=%0d match=%0d required 1 1", n_fail, n_match);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] good[4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    int n_match = 0, n_fail = 0;
    hard_reset();
    cyc(4'b0, 1'b1, 8'h72);
    cyc(4'b0100, 1'b0, 8'h00);
    cyc(4'b0, 1'b0, 8'h00);
    cyc(4'b0001, 1'b0, 8'h00);
    checks++;
    if (progress !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: progress=%0d busy=%b required 2 1", progress, busy);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected %b", dut_vec, exp_vec());
    end
    repeat (2) @(posedge clk);
    #1;
    n_fail += int'(fail);
    reset_n = 1'b1;
    cyc(4'b0, 1'b1, 8'h72);
    n_fail += int'(fail);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        cyc((g == 0) ? good[k] : 4'b0, 1'b0, 8'h00);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL reset_mid_retry e%0d g%0d: got %b expected %b", k, g, dut_vec, exp_vec());
        end
        n_match += int'(match);
        n_fail  += int'(fail);
      end
    end
    checks++;
    if (n_fail != 0 || n_match != 1) begin
      errors++;
      $display("FAIL reset_mid_summary: fail=%0d match=%0d required 0 1", n_fail, n_match);
    end
  endtask

  task automatic test_lockout();
    logic [3:0] bad[4]  = '{4'b0100, 4'b0010, 4'b1000, 4'b0010};
    logic [3:0] good[4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    int n_locked = 0, n_match = 0;
`ifdef PATTERN_CTRL_LOCKOUT_EN
    int exp_locked = LCK;
`else
    int exp_locked = 0;
`endif
    hard_reset();
    cyc(4'b0, 1'b1, 8'h72);
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k < 4; k++) begin
        for (int g = 0; g < 2; g++) begin
          cyc((g == 0) ? bad[k] : 4'b0, 1'b0, 8'h00);
          checks++;
          if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL lock_wrong a%0d e%0d: got %b expected %b", a, k, dut_vec, exp_vec());
          end
          n_locked += int'(locked);
        end
      end
    end
    for (int k = 0; k < 32; k++) begin
      cyc((k < 20) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0, (k == 5), 8'h00);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL lock_window k%0d: got %b expected %b", k, dut_vec, exp_vec());
      end
      n_locked += int'(locked);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        cyc((g == 0) ? good[k] : 4'b0, 1'b0, 8'h00);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL lock_after e%0d g%0d: got %b expected %b", k, g, dut_vec, exp_vec());
        end
        n_match += int'(match);
      end
    end
    checks++;
    if (n_locked != exp_locked || n_match != 1) begin
      errors++;
      $display("FAIL lock_summary: locked cycles=%0d match=%0d required %0d 1",
               n_locked, n_match, exp_locked);
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] b;
    hard_reset();
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) b = 4'b0;
      else if (r < 85 && (m_phase == PH_IDLE || m_phase == PH_COLLECT))
        b = 4'b0001 << mp[got.size()];
      else if (r < 95) b = 4'b0001 << $urandom_range(0, 3);
      else b = 4'($urandom_range(1, 15));
      cyc(b, ($urandom_range(0, 19) == 0), 8'($urandom));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b expected %b", k, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    btn_pulse    = 4'b0;
    pattern_load = 1'b0;
    pattern_in   = 8'h00;
    model_reset();
    test_reset();
    test_match();
    test_mismatch();
    test_timeout();
    test_invalid_and_load();
    test_reset_mid();
    test_lockout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
